shift_seq_unit: RTL
===================

Name: shift_seq_unit

Overview:
- Multi-cycle sequential shift engine for the ALU datapath.
- Loads an operand and applies a 1-bit shift per clock for a programmed amount, under a start/done handshake.
- Feeds the ALU result mux with a shifted word and a carry-out flag.
- Sits directly upstream of the ALU result register and reuses the single-step shift primitive the serial shifter already uses.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2).
- AMT_W, 3, width of the shift-amount input; max amount = 2^AMT_W − 1, must be ≤ WIDTH − 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
- amt  input  AMT_W  number of 1-bit steps.
- a  input  WIDTH  operand.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse when result is valid.
- y  output  WIDTH  result register.
- carry_out  output  1  last bit shifted or rotated out.

Behaviour:
- Reset values (async on rst high): state=IDLE, y=0, carry_out=0, done=0, busy=0, counter=0, latched op=00.
- FSM states are IDLE, SHIFT and DONE.
- IDLE, start=1 at a clock edge:
  - y ← a; op and amt are latched; carry_out ← 0.
  - If amt=0, next state is DONE; otherwise counter ← amt and next state is SHIFT.
- SHIFT, each edge:
  - y ← one-step shift of y per the latched op; carry_out ← the bit leaving the word.
  - counter decrements by 1.
  - When counter=1 at the edge, next state is DONE.
- DONE: done=1 for exactly one cycle; the next edge returns to IDLE.
- Shift rules per step:
  - LSL: zero-fill LSB; carry = old MSB.
  - LSR: zero-fill MSB; carry = old LSB.
  - ASR: MSB replicated; carry = old LSB.
  - ROR: old LSB moves to MSB; carry = old LSB.
- Latency: done asserts amt+1 cycles after the accepting edge (1 cycle when amt=0).
- start is ignored while busy. Changes to a, op and amt after acceptance have no effect.
- A start in the DONE cycle is ignored; a new op is accepted from the IDLE cycle onward.
- y and carry_out hold their values in IDLE until the next accepted start.
- rst asserted mid-operation aborts immediately to the reset values; no done pulse is issued.
- Outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: SHIFT_SEQ_ROTATE_EN.
- Defined: op=11 performs ROR as specified above.
- Undefined: ROR logic is not built; op=11 is decoded as LSR, with identical timing and handshake.

Decomposition:
- Package shift_seq_pkg contains:
  - op encoding constants OP_LSL, OP_LSR, OP_ASR, OP_ROR;
  - the FSM state typedef with IDLE, SHIFT and DONE.
- One natural sub-module, shift_step: a combinational single-bit step taking (op, word) and producing (next_word, carry).
- shift_step is parameterised by WIDTH and instantiated once in shift_seq_unit.

Test Plan:
- LSL, a=8'b10101010, amt=3, start pulse → done high 4 cycles after accept; y=8'b01010000; carry_out=1; busy low afterwards.
- ASR, a=8'b11001101, amt=2 → y=8'b11110011, carry_out=0, done 3 cycles after accept.
- ROR (macro defined), a=8'b11001101, amt=4 → y=8'b11011100, carry_out=1. Same stimulus with the macro undefined (LSR) → y=8'b00001100, carry_out=1.
- amt=0, a=8'hA5, any op → done 1 cycle after accept; y=8'hA5; carry_out=0.
- LSR, a=8'hFF, amt=7 → y=8'h01, carry_out=1. A second start pulsed during SHIFT is ignored: exactly one done pulse, and y is unaffected.
- Assert rst 2 cycles into an amt=5 operation → y=0, busy=0, done never pulses. After release, a fresh start with amt=1, LSL, a=8'h81 → y=8'h02, carry_out=1.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// rtl/shift_seq_pkg.sv - op encodings and FSM state type for the sequential shift engine.
package shift_seq_pkg;

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational single-bit shift/rotate step.
// ROR is built only when SHIFT_SEQ_ROTATE_EN is defined; otherwise op=11 behaves as LSR.
module shift_step
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] word,
  output logic [WIDTH-1:0] next_word,
  output logic             carry
);

  always_comb begin
    // LSR is the fallback for any op not decoded below.
    next_word = {1'b0, word[WIDTH-1:1]};
    carry     = word[0];
    case (op)
      OP_LSL: begin
        next_word = {word[WIDTH-2:0], 1'b0};
        carry     = word[WIDTH-1];
      end
      OP_ASR: begin
        next_word = {word[WIDTH-1], word[WIDTH-1:1]};
        carry     = word[0];
      end
`ifdef SHIFT_SEQ_ROTATE_EN
      OP_ROR: begin
        next_word = {word[0], word[WIDTH-1:1]};
        carry     = word[0];
      end
`endif
      default: begin
        next_word = {1'b0, word[WIDTH-1:1]};
        carry     = word[0];
      end
    endcase
  end

endmodule

// File: rtl/shift_seq_unit.sv
// rtl/shift_seq_unit.sv - multi-cycle shift engine, one bit per clock under start/done handshake.
// SHIFT_SEQ_ROTATE_EN enables ROR for op=11 (otherwise decoded as LSR).
module shift_seq_unit
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] a,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             carry_out
);

  state_t           state;
  state_t           state_n;
  logic [AMT_W-1:0] counter;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] step_word;
  logic             step_carry;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op        (op_q),
    .word      (y),
    .next_word (step_word),
    .carry     (step_carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = (amt == '0) ? DONE : SHIFT;
      SHIFT:   if (counter == AMT_W'(1)) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y         <= '0;
      carry_out <= 1'b0;
      counter   <= '0;
      op_q      <= OP_LSL;
    end else if (state == IDLE && start) begin
      y         <= a;
      carry_out <= 1'b0;
      counter   <= amt;
      op_q      <= op;
    end else if (state == SHIFT) begin
      y         <= step_word;
      carry_out <= step_carry;
      counter   <= counter - AMT_W'(1);
    end
  end

  // Both flags decode the state register only, so no input reaches an output combinationally.
  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
